// File: rtl/lsu_ram_ctrl.sv
// Load/store front-end for a single-port, word-wide data RAM.
// Handles RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW: load lane extraction and extension,
// sub-word stores as read-modify-write, and early rejection of misaligned or
// illegal-funct3 requests without touching memory.
module lsu_ram_ctrl #(
  parameter int unsigned DEPTH      = 2**16,
  parameter int unsigned DATA_WIDTH = 32,
  localparam int unsigned AW        = $clog2(DEPTH) + 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req,
  output logic                  o_ready,
  input  logic                  i_we,
  input  logic [2:0]            i_funct3,
  input  logic [AW-1:0]         i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  o_done,
  output logic                  o_err,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_ram_en,
  output logic                  o_ram_we,
  output logic [AW-3:0]         o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_wdata,
  input  logic [DATA_WIDTH-1:0] i_ram_rdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_WRITE = 2'd3;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  logic [1:0]            state_q, state_d;
  logic                  we_q, we_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  req_illegal;
  logic                  req_misaligned;
  logic                  is_sw;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;
  logic [DATA_WIDTH-1:0] load_fmt;
  logic [DATA_WIDTH-1:0] merged;

  assign o_ready = (state_q == S_IDLE);
  assign o_done  = done_q;
  assign o_err   = err_q;
  assign o_rdata = rdata_q;
  assign is_sw   = we_q && (funct3_q == F3_W);

  // Classify the incoming request: illegal funct3 or misaligned for its size.
  always_comb begin
    req_illegal    = 1'b0;
    req_misaligned = 1'b0;
    if (i_we) begin
      req_illegal = (i_funct3 >= 3'b011);
    end else begin
      req_illegal = (i_funct3 == 3'b011) || (i_funct3[2:1] == 2'b11);
    end
    if (i_funct3[1:0] == 2'b01) begin
      req_misaligned = i_addr[0];
    end else if (i_funct3[1:0] == 2'b10) begin
      req_misaligned = (i_addr[1:0] != 2'b00);
    end
  end

  // Extract the addressed lane from the read word and extend it for loads.
  always_comb begin
    rd_byte  = '0;
    rd_half  = '0;
    load_fmt = '0;
    case (addr_q[1:0])
      2'd0:    rd_byte = i_ram_rdata[7:0];
      2'd1:    rd_byte = i_ram_rdata[15:8];
      2'd2:    rd_byte = i_ram_rdata[23:16];
      default: rd_byte = i_ram_rdata[31:24];
    endcase
    rd_half = addr_q[1] ? i_ram_rdata[31:16] : i_ram_rdata[15:0];
    case (funct3_q)
      F3_B:    load_fmt = {{24{rd_byte[7]}}, rd_byte};
      F3_H:    load_fmt = {{16{rd_half[15]}}, rd_half};
      F3_BU:   load_fmt = {24'd0, rd_byte};
      F3_HU:   load_fmt = {16'd0, rd_half};
      default: load_fmt = i_ram_rdata;
    endcase
  end

  // Splice store data into the word read back for a sub-word store.
  always_comb begin
    merged = i_ram_rdata;
    if (funct3_q[1:0] == 2'b00) begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else if (funct3_q[1:0] == 2'b01) begin
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
  end

  // Sequencer: accept, issue, wait for read data, optional write-back.
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    rdata_d  = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (i_req) begin
          we_d     = i_we;
          funct3_d = i_funct3;
          addr_d   = i_addr;
          wdata_d  = i_wdata;
          if (req_illegal || req_misaligned) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (is_sw) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!we_q) begin
          rdata_d = load_fmt;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          // The write-back word reuses the store-data register.
          wdata_d = merged;
          state_d = S_WRITE;
        end
      end
      default: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // Drive the RAM port from state and captured fields; reset blocks any access.
  always_comb begin
    o_ram_en    = 1'b0;
    o_ram_we    = 1'b0;
    o_ram_addr  = addr_q[AW-1:2];
    o_ram_wdata = '0;
    if (state_q == S_ISSUE) begin
      o_ram_en = !i_rst;
      if (is_sw) begin
        o_ram_we    = !i_rst;
        o_ram_wdata = wdata_q;
      end
    end else if (state_q == S_WRITE) begin
      o_ram_en    = !i_rst;
      o_ram_we    = !i_rst;
      o_ram_wdata = wdata_q;
    end
  end

  // State and request registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule
